// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite register-file slave with independent AW/W holding buffers,
// read-only hardware status slots and per-register write pulses.
module axi_lite_slave_regfile #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        REG_NUM   = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [REG_NUM-1:0] RO_MASK   = '0,
    parameter logic [DATA_W-1:0]  ERR_DATA  = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_W-1:0]         araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [REG_NUM*DATA_W-1:0] reg_q,
    output logic [REG_NUM-1:0]        wr_pulse,
    input  logic [REG_NUM*DATA_W-1:0] hw_status
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef logic [IDX_W-1:0] idx_t;
    typedef struct packed {
        logic err;
        idx_t idx;
    } dec_t;

    function automatic dec_t decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        dec_t              d;
        off   = a - BASE_ADDR;
        d.idx = off[LSB +: IDX_W];
        d.err = (a < BASE_ADDR)
              || (off[LSB-1:0] != '0)
              || ((off >> LSB) >= ADDR_W'(REG_NUM));
        return d;
    endfunction

    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [DATA_W-1:0]  hw_arr [REG_NUM];

    logic               aw_full_q, aw_full_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic               w_full_q, w_full_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BYTES-1:0]   wstrb_q, wstrb_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [REG_NUM-1:0] wr_pulse_q, wr_pulse_d;

    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    dec_t wdec;
    dec_t rdec;
    logic commit;

    assign wdec   = decode(awaddr_q);
    assign rdec   = decode(araddr);
    assign commit = aw_full_q && w_full_q && !bvalid_q;

    for (genvar i = 0; i < REG_NUM; i++) begin : g_slot
        assign hw_arr[i] = hw_status[i*DATA_W +: DATA_W];
        assign reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
    end

    always_comb begin
        regs_d     = regs_q;
        aw_full_d  = aw_full_q;
        awaddr_d   = awaddr_q;
        w_full_d   = w_full_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;

        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!wdec.err && !RO_MASK[wdec.idx]) begin
                bresp_d              = OKAY;
                wr_pulse_d[wdec.idx] = 1'b1;
                for (int b = 0; b < BYTES; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[wdec.idx][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end
            end else begin
                bresp_d = SLVERR;
            end
        end

        // Ready is high only when the buffer is empty, so capture never
        // coincides with a commit of the same buffer.
        if (awvalid && awready_q) begin
            aw_full_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (wvalid && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end

        if (arvalid && arready_q) begin
            rvalid_d = 1'b1;
            if (rdec.err) begin
                rresp_d = SLVERR;
                rdata_d = ERR_DATA;
            end else if (RO_MASK[rdec.idx]) begin
                rresp_d = OKAY;
                rdata_d = hw_arr[rdec.idx];
            end else begin
                rresp_d = OKAY;
                rdata_d = regs_q[rdec.idx];
            end
        end

        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            aw_full_q  <= 1'b0;
            awaddr_q   <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            aw_full_q  <= aw_full_d;
            awaddr_q   <= awaddr_d;
            w_full_q   <= w_full_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign wr_pulse = wr_pulse_q;
    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rresp    = rresp_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile: vector table plus
// hand-written latency, back-pressure, reset and same-edge sequences.
module tb_axi_lite_slave_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_q;
    logic [3:0]   wr_pulse;
    logic [127:0] hw_status;

    int errors = 0;
    int checks = 0;
    logic [31:0] m [4];

    always #5 clk = ~clk;

    axi_lite_slave_regfile #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .REG_NUM  (4),
        .BASE_ADDR(32'h100),
        .RO_MASK  (4'b1000),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .hw_status(hw_status)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdat;
        logic [3:0]  pulse;
        string       nm;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d,
                                logic [3:0] s, logic [1:0] r,
                                logic [31:0] rd, logic [3:0] p,
                                string n);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.strb = s;
        v.resp = r; v.rdat = rd; v.pulse = p; v.nm = n;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    function automatic logic [127:0] model_q();
        return {32'h0, m[2], m[1], m[0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] r,
                         output logic [3:0] p);
        bit ad = 0;
        bit wd = 0;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        while (!(ad && wd) && n < 20) begin
            @(negedge clk);
            if (awready) ad = 1;
            if (wready) wd = 1;
            cyc();
            if (ad) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (n >= 20) tmo("wr addr/data");
        r = 2'b11; p = '0; n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bvalid) begin
                r = bresp;
                p = wr_pulse;
                break;
            end
            cyc();
            n++;
        end
        if (n >= 20) tmo("wr resp");
        bready = 1'b1;
        cyc();
        bready = 1'b0;
    endtask

    task automatic do_rd(input logic [31:0] a, output logic [1:0] r,
                         output logic [31:0] d);
        bit ok = 0;
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (arready) ok = 1;
            cyc();
            n++;
        end
        arvalid = 1'b0;
        if (!ok) tmo("rd addr");
        r = 2'b11; d = '0; n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (rvalid) begin
                r = rresp;
                d = rdata;
                break;
            end
            cyc();
            n++;
        end
        if (n >= 20) tmo("rd data");
        rready = 1'b1;
        cyc();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  r;
        logic [3:0]  p;
        logic [31:0] d;
        int          ix;

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arvalid = 1'b0;
        rready = 1'b0;
        hw_status = {32'hCAFE_0003, 32'hBAD0_0002,
                     32'hBAD0_0001, 32'hBAD0_0000};
        for (int i = 0; i < 4; i++) m[i] = '0;

        // reset state
        repeat (3) cyc();
        chk("rst ready", {awready, wready, arready}, 0);
        chk("rst valid", {bvalid, rvalid, wr_pulse}, 0);
        chk("rst resp", {bresp, rresp, rdata}, 0);
        chk("rst regs", reg_q, 0);
        rst = 1'b0;
        cyc();
        chk("ready rise", {awready, wready, arready}, 3'b111);

        // write latency: handshake cycle 0, response cycle 2
        awaddr = 32'h108; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("lat c1 bvalid", {bvalid, awready, wready}, 0);
        cyc();
        chk("lat c2 bvalid", {bvalid, bresp}, 3'b100);
        chk("lat c2 pulse", wr_pulse, 4'b0100);
        chk("lat c2 reg2", reg_q[64 +: 32], 32'h1234_5678);
        m[2] = 32'h1234_5678;
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        chk("lat c3 pulse", {bvalid, wr_pulse}, 0);

        vt.push_back(mk(1, 32'h108, 32'h1234_5678, 4'hF, 2'b00, 0, 4'b0100, "wr reg2"));
        vt.push_back(mk(0, 32'h108, 0, 0, 2'b00, 32'h1234_5678, 0, "rd reg2"));
        vt.push_back(mk(1, 32'h104, 32'hAAAA_AAAA, 4'hF, 2'b00, 0, 4'b0010, "wr reg1"));
        vt.push_back(mk(1, 32'h104, 32'h1122_3344, 4'b0101, 2'b00, 0, 4'b0010, "strb merge"));
        vt.push_back(mk(0, 32'h104, 0, 0, 2'b00, 32'hAA22_AA44, 0, "rd merged"));
        vt.push_back(mk(1, 32'h110, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0, "wr oor"));
        vt.push_back(mk(0, 32'h0FC, 0, 0, 2'b10, 32'hDEAD_BEEF, 0, "rd below"));
        vt.push_back(mk(0, 32'h102, 0, 0, 2'b10, 32'hDEAD_BEEF, 0, "rd misalign"));
        vt.push_back(mk(0, 32'h10C, 0, 0, 2'b00, 32'hCAFE_0003, 0, "rd ro"));
        vt.push_back(mk(1, 32'h10C, 32'h55, 4'hF, 2'b10, 0, 0, "wr ro"));
        vt.push_back(mk(1, 32'h100, 32'hFFFF_FFFF, 4'h0, 2'b00, 0, 4'b0001, "wr strb0"));
        vt.push_back(mk(1, 32'h102, 32'h9999_9999, 4'hF, 2'b10, 0, 0, "wr misalign"));
        vt.push_back(mk(0, 32'h110, 0, 0, 2'b10, 32'hDEAD_BEEF, 0, "rd oor"));
        vt.push_back(mk(1, 32'h0F8, 32'h7777_7777, 4'hF, 2'b10, 0, 0, "wr below"));

        foreach (vt[k]) begin
            if (vt[k].wr) begin
                do_wr(vt[k].addr, vt[k].data, vt[k].strb, r, p);
                chk({vt[k].nm, " resp"}, r, vt[k].resp);
                chk({vt[k].nm, " pulse"}, p, vt[k].pulse);
                if (vt[k].resp == 2'b00) begin
                    ix = int'((vt[k].addr - 32'h100) >> 2);
                    for (int b = 0; b < 4; b++) begin
                        if (vt[k].strb[b]) m[ix][b*8 +: 8] = vt[k].data[b*8 +: 8];
                    end
                end
                chk({vt[k].nm, " regs"}, reg_q, model_q());
            end else begin
                do_rd(vt[k].addr, r, d);
                chk({vt[k].nm, " resp"}, r, vt[k].resp);
                chk({vt[k].nm, " data"}, d, vt[k].rdat);
            end
        end

        // W three cycles ahead of AW, then B held off with a second write queued
        awaddr = 32'h100; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        cyc();
        wvalid = 1'b0;
        chk("ooo w held", wready, 0);
        repeat (2) cyc();
        awvalid = 1'b1;
        cyc();
        awvalid = 1'b0;
        cyc();
        chk("ooo bvalid", {bvalid, bresp}, 3'b100);
        chk("ooo reg0", reg_q[31:0], 32'h77);
        wdata = 32'h88; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            awvalid = 1'b0; wvalid = 1'b0;
            chk("bp hold", {bvalid, bresp, reg_q[31:0]}, {3'b100, 32'h77});
        end
        chk("bp 2nd held", {awready, wready}, 0);
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        chk("bp b done", bvalid, 0);
        cyc();
        chk("bp 2nd commit", {bvalid, wr_pulse, reg_q[31:0]}, {5'b10001, 32'h88});
        bready = 1'b1;
        cyc();
        bready = 1'b0;

        // reset with a write held in the buffers
        awaddr = 32'h100; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("mid rst outs", {awready, wready, arready, bvalid, rvalid,
                             bresp, rresp, rdata, wr_pulse}, 0);
        chk("mid rst regs", reg_q, 0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("post rst", {bvalid, wr_pulse, awready, wready}, 6'b000011);
        chk("post rst regs", reg_q, 0);

        // read on the same edge as a commit to the same register
        awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h100; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        chk("same edge rd", {rvalid, rresp, rdata}, {3'b100, 32'h0});
        chk("same edge wr", {bvalid, reg_q[31:0]}, {1'b1, 32'h5});
        rready = 1'b1; bready = 1'b1;
        cyc();
        rready = 1'b0; bready = 1'b0;
        do_rd(32'h100, r, d);
        chk("rd after", {r, d}, {2'b00, 32'h5});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regfile.md
# axi_lite_slave_regfile

Parametrised AXI4-Lite register-file slave: the next generation of the team's AXI-lite register block, generalised in data width, register count and base address. Adds independent AW/W acceptance with one-entry holding buffers, full B/R back-pressure, per-register read-only status registers fed from hardware, and per-register write strobes to the fabric. It sits between the AXI-lite interconnect and the block's control/status logic.

## Interface
Parameters:
- DATA_W, 32, data width; legal values are 32 or 64.
- ADDR_W, 32, address width.
- REG_NUM, 16, number of registers; range 1..256.
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_W/8.
- RO_MASK, 0, REG_NUM bits; bit i=1 makes register i read-only, and reads return hw_status slice i.
- ERR_DATA, 'hDEAD_BEEF (zero-extended), rdata value returned with SLVERR.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- awaddr  in  ADDR_W; awvalid in 1; awready out 1.
- wdata  in  DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1.
- bresp  out  2; bvalid out 1; bready in 1.
- araddr  in  ADDR_W; arvalid in 1; arready out 1.
- rdata  out  DATA_W; rresp out 2; rvalid out 1; rready in 1.
- reg_q  out  REG_NUM*DATA_W  current register contents; register i occupies [i*DATA_W +: DATA_W]. RO slots drive 0.
- wr_pulse  out  REG_NUM  one-cycle pulse per successfully written register.
- hw_status  in  REG_NUM*DATA_W  values returned on reads of RO registers.

## Operation
Decode, applied identically to write and read addresses:
- BYTES = DATA_W/8.
- off = addr - BASE_ADDR.
- idx = off / BYTES.
- Error (SLVERR, 2'b10) if addr < BASE_ADDR, or off mod BYTES != 0, or idx >= REG_NUM.
- Otherwise OKAY (2'b00).

Write path:
- AW holding register (aw_full) and W holding register (w_full) each capture on their own handshake. AW and W may arrive in any order or in the same cycle.
- awready = !aw_full; wready = !w_full. Both are driven directly from flops.
- Commit condition: aw_full && w_full && !bvalid.
- On commit, if the decode is OK and the register is not RO:
  - merge the held data into reg[idx] per byte lane, for each set wstrb bit;
  - set wr_pulse[idx] for one cycle;
  - return bresp=OKAY.
- On commit, if the address is an RO register or a decode error: no register change, no pulse, bresp=SLVERR.
- wstrb==0 to a valid RW register: no data change, wr_pulse is still asserted, OKAY.
- On commit: bvalid<=1, and both holding registers are cleared.
- bvalid falls on bvalid && bready.
- A new commit is blocked while bvalid=1. AW/W may still fill the holding registers, so at most one write is pending behind the outstanding B response.

Read path:
- arready = !rvalid.
- On an AR handshake:
  - rdata is loaded from reg[idx], or from hw_status[idx] if the register is RO, or with ERR_DATA on error;
  - rresp is loaded (OKAY or SLVERR);
  - rvalid<=1.
- rvalid falls on rvalid && rready. rdata and rresp hold stable while rvalid=1.

Simultaneous events:
- An AR handshake on the same edge as a write commit to the same register returns the pre-commit value.
- Read and write paths are fully independent; neither stalls the other.

Reset (rst=1 at a clock edge):
- All registers become 0; aw_full and w_full are cleared.
- Outputs: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0.
- The ready outputs rise the first cycle after rst deasserts.
- Reset mid-transaction discards held AW/W data and any pending response; no write takes effect.

## Timing
- Write latency: AW and W handshakes in cycle 0 → capture at the end of cycle 0 → commit at the end of cycle 1 → bvalid, wr_pulse and reg_q update visible in cycle 2.
- Back-to-back writes with bready=1: bvalid is high every other cycle. Sustained write throughput is one write per 2 cycles.
- Read latency: AR handshake in cycle 0 → rvalid/rdata in cycle 1.
- Back-to-back reads with rready=1: one read per 2 cycles (arready is low while rvalid is high).
- No combinational path from any input to any output.

## Test plan
- Reset then write: with DATA_W=32, write 0x1234_5678, wstrb=0xF, to BASE+0x8. Required: bvalid in cycle 2 with OKAY, wr_pulse[2] for 1 cycle, reg_q slice 2 = 0x1234_5678. A subsequent read of the same address returns the same value with OKAY.
- Strobe merge: reg1=0xAAAA_AAAA, then write 0x1122_3344 with wstrb=0b0101. Required: reg1=0xAA22_AA44.
- Out-of-order and back-pressure: W presented 3 cycles before AW, with bready held low 4 cycles. Required:
  - bvalid stays high and bresp stable until bready;
  - a second AW+W is captured but not committed until the first B completes.
- Errors: with REG_NUM=4, BASE=0x100:
  - write to 0x110 → SLVERR, no reg change, no pulse;
  - read of 0x0FC → SLVERR, rdata=ERR_DATA;
  - read of 0x102 (misaligned) → SLVERR.
- RO register: RO_MASK=4'b1000 and hw_status slice 3=0xCAFE_0003. Required:
  - read of reg3 returns 0xCAFE_0003 with OKAY;
  - write to reg3 → SLVERR, no pulse.
- Same-edge read/write and mid-operation reset:
  - AR to reg0 on the commit edge of a write of 0x5 to reg0, with old value 0x0 → rdata=0x0;
  - rst pulsed with AW/W held → no write occurs, all outputs 0, regs 0.
